// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: ID-stage control in, instruction-memory port,
// and the IF/ID pipeline-register write side.
interface if_fetch_unit_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ifid_le;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;

    // Fetch unit side
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_req, imem_addr, ifid_le, ifid_instr, ifid_pc
    );

    // Environment side: ID stage, instruction memory, IF/ID register
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, ifid_le, ifid_instr, ifid_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Issues reads to a 1-cycle-latency instruction
// memory, buffers returned words in a 2-entry skid FIFO so ID stalls never
// lose or duplicate an instruction, and applies ID-stage redirects.
module if_fetch_unit #(
    parameter int              PC_W     = 9,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_unit_if.master  bus
);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    logic [PC_W-1:0]    fetch_pc_q,    fetch_pc_d;
    logic               inflight_q,    inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic               drop_q,        drop_d;
    logic [1:0]         cnt_q,         cnt_d;
    logic [INSTR_W-1:0] fifo_instr_q [2];
    logic [INSTR_W-1:0] fifo_instr_d [2];
    logic [PC_W-1:0]    fifo_pc_q    [2];
    logic [PC_W-1:0]    fifo_pc_d    [2];

    logic       arriving;
    logic       issue;
    logic       consume;
    logic [2:0] occupancy;
    logic [1:0] cnt_tmp;

    // Next-state, issue decision and IF/ID drive for the current cycle
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        cnt_d         = cnt_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        cnt_tmp       = cnt_q;
        consume       = 1'b0;

        bus.ifid_le    = 1'b0;
        bus.ifid_instr = '0;
        bus.ifid_pc    = '0;

        // Occupancy counts the word still in flight so a push can never
        // land in a full FIFO.
        arriving  = inflight_q && !drop_q;
        occupancy = {1'b0, cnt_q} + {2'b0, inflight_q};
        issue     = !reset && !bus.redirect && (occupancy < 3'd2);

        bus.imem_req  = issue;
        bus.imem_addr = fetch_pc_q;

        if (reset) begin
            // Outputs stay quiet; the flops load their reset values.
        end else if (bus.redirect) begin
            // Flush: bubble into IF/ID, discard buffered and returning words.
            bus.ifid_le = 1'b1;
            cnt_d       = 2'd0;
            fetch_pc_d  = bus.redirect_pc;
            drop_d      = inflight_q;
            inflight_d  = 1'b0;
        end else begin
            bus.ifid_le = !bus.stall;

            // Head is the oldest buffered word, else the arriving word.
            if (cnt_q != 2'd0) begin
                bus.ifid_instr = fifo_instr_q[0];
                bus.ifid_pc    = fifo_pc_q[0];
            end else if (arriving) begin
                bus.ifid_instr = bus.imem_rdata;
                bus.ifid_pc    = inflight_pc_q;
            end
            consume = !bus.stall && ((cnt_q != 2'd0) || arriving);

            if (consume && (cnt_q != 2'd0)) begin
                fifo_instr_d[0] = fifo_instr_q[1];
                fifo_pc_d[0]    = fifo_pc_q[1];
                cnt_tmp         = cnt_q - 2'd1;
            end

            // Arriving word not taken by bypass goes behind any older entry.
            if (arriving && !(consume && (cnt_q == 2'd0))) begin
                if (cnt_tmp == 2'd0) begin
                    fifo_instr_d[0] = bus.imem_rdata;
                    fifo_pc_d[0]    = inflight_pc_q;
                end else begin
                    fifo_instr_d[1] = bus.imem_rdata;
                    fifo_pc_d[1]    = inflight_pc_q;
                end
                cnt_tmp = cnt_tmp + 2'd1;
            end
            cnt_d = cnt_tmp;

            drop_d     = 1'b0;
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_STEP;
            end
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
        end
    end

    // FIFO payload; validity is tracked by cnt_q so no reset is needed
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                fifo_instr_q[gi] <= fifo_instr_d[gi];
                fifo_pc_q[gi]    <= fifo_pc_d[gi];
            end
        end
    endgenerate
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random
// stall/redirect/reset traffic, all checked against a queue-based model.
module tb_if_fetch_unit;
    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;
    localparam int PC_MOD  = 1 << PC_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    if_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .PC_INC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [INSTR_W-1:0] imem_word(input int addr);
        return INSTR_W'(addr) << 8;
    endfunction

    // Synchronous instruction memory; garbage when no request was made
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= imem_word(int'(bus.imem_addr));
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: next fetch address, at most one outstanding read,
    // and an in-order list of fetched-but-undelivered PCs.
    int m_pc       = 0;
    bit m_pend     = 0;
    int m_pend_pc  = 0;
    int m_q[$];

    int unsigned o_req, o_addr, o_le, o_instr, o_pc;

    task automatic model_step(input bit r, input bit s, input bit rd, input int rpc);
        int lst[$];
        bit e_req;
        bit e_le;
        int e_pc;
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_le    = bus.ifid_le;
        o_instr = bus.ifid_instr;
        o_pc    = bus.ifid_pc;
        if (o_le != 0)
            $display("[TB] cyc %0d IF/ID load pc=0x%03h instr=0x%08h", cyc, o_pc, o_instr);
        if (r) begin
            check("rst_req", o_req, 0);
            check("rst_le", o_le, 0);
            check("rst_instr", o_instr, 0);
            check("rst_pc", o_pc, 0);
            m_pc = 0;
            m_pend = 0;
            m_q.delete();
            return;
        end
        e_req = !rd && ((m_q.size() + int'(m_pend)) < 2);
        check("imem_req", o_req, e_req);
        check("imem_addr", o_addr, m_pc);
        lst = m_q;
        if (m_pend) lst.push_back(m_pend_pc);
        if (rd) begin
            check("redir_le", o_le, 1);
            check("redir_instr", o_instr, 0);
            check("redir_pc", o_pc, 0);
            m_q.delete();
            m_pend = 0;
            m_pc = rpc;
        end else begin
            e_le = !s;
            check("ifid_le", o_le, e_le);
            if (e_le) begin
                if (lst.size() > 0) begin
                    e_pc = lst.pop_front();
                    check("ifid_pc", o_pc, e_pc);
                    check("ifid_instr", o_instr, imem_word(e_pc));
                end else begin
                    check("bubble_pc", o_pc, 0);
                    check("bubble_instr", o_instr, 0);
                end
            end
            m_q = lst;
            m_pend = e_req;
            m_pend_pc = m_pc;
            if (e_req) m_pc = (m_pc + 4) % PC_MOD;
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit rd, input int rpc);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = PC_W'(rpc);
        @(negedge clk);
        model_step(r, s, rd, rpc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int exp_seq[4] = '{32'h1F8, 32'h1FC, 32'h000, 32'h004};

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cyc = 0;

        // Cold start: addresses 0,4,8; first word in IF/ID one cycle later
        cycle(0, 0, 0, 0); check("t1_addr_c0", o_addr, 0);
        cycle(0, 0, 0, 0); check("t1_addr_c1", o_addr, 4);
        check("t1_le_c1", o_le, 1); check("t1_pc_c1", o_pc, 0);
        cycle(0, 0, 0, 0); check("t1_addr_c2", o_addr, 8); check("t1_pc_c2", o_pc, 4);

        // Stall cycles 3-6: FIFO fills, requests stop, nothing loaded
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        check("t2_req_full", o_req, 0); check("t2_le_stall", o_le, 0);
        cycle(0, 0, 0, 0); check("t2_resume_pc", o_pc, 8);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Redirect with a request in flight
        cycle(0, 0, 1, 32'h040); check("t3_le", o_le, 1); check("t3_instr", o_instr, 0);
        cycle(0, 0, 0, 0); check("t3_addr", o_addr, 32'h040);
        cycle(0, 0, 0, 0); check("t3_pc", o_pc, 32'h040);

        // Redirect while stalled with a full FIFO
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h100); check("t4_le", o_le, 1); check("t4_instr", o_instr, 0);
        cycle(0, 0, 0, 0); check("t4_addr", o_addr, 32'h100);
        cycle(0, 0, 0, 0); check("t4_pc", o_pc, 32'h100);

        // PC wrap with no gap
        cycle(0, 0, 1, 32'h1F8);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            if (i < 4) check("t5_addr", o_addr, exp_seq[i]);
            if (i > 0) check("t5_pc", o_pc, exp_seq[i-1]);
        end

        // Reset mid-stall with a full FIFO
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0); check("t6_addr", o_addr, 0); check("t6_le", o_le, 1);
        check("t6_bubble", o_instr, 0);
        cycle(0, 0, 0, 0); check("t6_pc", o_pc, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit s;
            bit rd;
            r  = ($urandom_range(0, 99) < 1);
            s  = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 8);
            cycle(r, s, rd, int'($urandom_range(0, 127)) * 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
